// File: rtl/sram_pkg.sv
// Shared SRAM helpers and request types, also used by the L1 cache controller.
// Default request widths follow the L1 data array geometry.
package sram_pkg;

    function automatic int sram_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int sram_num_wmasks(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    localparam int SRAM_DATA_WIDTH = 1024;
    localparam int SRAM_DEPTH      = 256;
    localparam int SRAM_BYTE_WIDTH = 8;
    localparam int SRAM_ADDR_WIDTH = sram_addr_w(SRAM_DEPTH);
    localparam int SRAM_NUM_WMASKS = sram_num_wmasks(SRAM_DATA_WIDTH, SRAM_BYTE_WIDTH);

    typedef struct packed {
        logic                       en;
        logic [SRAM_ADDR_WIDTH-1:0] addr;
    } sram_rd_req_t;

    typedef struct packed {
        logic                       en;
        logic [SRAM_ADDR_WIDTH-1:0] addr;
        logic [SRAM_NUM_WMASKS-1:0] mask;
        logic [SRAM_DATA_WIDTH-1:0] data;
    } sram_wr_req_t;

endpackage

// File: rtl/sram_wmask_merge.sv
// Combinational byte-lane merge: lanes with mask=1 take new_data, others keep old_data.
module sram_wmask_merge import sram_pkg::*; #(
    parameter int DATA_WIDTH = 1024,
    parameter int BYTE_WIDTH = 8,
    parameter int NUM_WMASKS = sram_num_wmasks(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] new_data,
    input  logic [DATA_WIDTH-1:0] old_data,
    input  logic [NUM_WMASKS-1:0] mask,
    output logic [DATA_WIDTH-1:0] merged
);

    logic [DATA_WIDTH-1:0] mask_bits;

    always_comb begin
        mask_bits = '0;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            mask_bits[BYTE_WIDTH*i +: BYTE_WIDTH] = {BYTE_WIDTH{mask[i]}};
        end
    end

    assign merged = (new_data & mask_bits) | (old_data & ~mask_bits);

endmodule

// File: rtl/l1_sram_1r1w_fwd.sv
// Single-clock 1R1W byte-masked SRAM with registered read and write-first collision forwarding.
// Define SRAM_OUT_REG_EN to add an output register stage (read latency 2 instead of 1).
module l1_sram_1r1w_fwd import sram_pkg::*; #(
    parameter int DATA_WIDTH = 1024,
    parameter int DEPTH      = 256,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = sram_addr_w(DEPTH),
    parameter int NUM_WMASKS = sram_num_wmasks(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WMASKS-1:0] wr_mask,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data
);

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] wr_old_p0;
    logic [DATA_WIDTH-1:0] wr_merged_p0;
    logic [DATA_WIDTH-1:0] rd_word_p0;
    logic                  collide_p0;

    assign wr_old_p0  = mem[wr_addr];
    assign collide_p0 = wr_en && rd_en && (wr_addr == rd_addr);

    // One merge serves both paths: on a collision wr_old_p0 is the read word too.
    sram_wmask_merge #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .NUM_WMASKS (NUM_WMASKS)
    ) u_merge (
        .new_data (wr_data),
        .old_data (wr_old_p0),
        .mask     (wr_mask),
        .merged   (wr_merged_p0)
    );

    assign rd_word_p0 = collide_p0 ? wr_merged_p0 : mem[rd_addr];

    // Array is never reset; a write seen while rst is high is dropped.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_addr] <= wr_merged_p0;
        end
    end

    // ---- p0 -> p1: read data fixed at acceptance ----
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= rd_en;
            if (rd_en) begin
                data_p1 <= rd_word_p0;
            end
        end
    end

`ifdef SRAM_OUT_REG_EN
    // ---- p1 -> p2: optional output register ----
    logic                  vld_p2;
    logic [DATA_WIDTH-1:0] data_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2 <= data_p1;
            end
        end
    end

    assign rd_valid = vld_p2;
    assign rd_data  = data_p2;
`else
    assign rd_valid = vld_p1;
    assign rd_data  = data_p1;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && rd_en && $isunknown(rd_addr)) begin
            $error("l1_sram_1r1w_fwd: unknown rd_addr while rd_en is high");
        end
        if (!rst && wr_en && $isunknown(wr_addr)) begin
            $error("l1_sram_1r1w_fwd: unknown wr_addr while wr_en is high");
        end
    end
`endif

endmodule

// File: tb/tb_l1_sram_1r1w_fwd.sv
// Directed bench for l1_sram_1r1w_fwd: vector table plus reset, sweep and collision sequences.
module tb_l1_sram_1r1w_fwd;

    localparam int DW  = 1024;
    localparam int DEP = 256;
    localparam int BW  = 8;
    localparam int AW  = 8;
    localparam int NM  = DW / BW;
`ifdef SRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [NM-1:0] wr_mask = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;

    always #5 clk = ~clk;

    l1_sram_1r1w_fwd #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEP),
        .BYTE_WIDTH (BW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_mask  (wr_mask),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

    typedef struct {
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [NM-1:0] wr_mask;
        logic [DW-1:0] wr_data;
        logic          rd_en;
        logic [AW-1:0] rd_addr;
        logic [DW-1:0] exp_data;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic          pv [2];
    logic [DW-1:0] pd [2];
    logic [DW-1:0] held;

    function automatic logic [DW-1:0] rep(input logic [7:0] b);
        return {NM{b}};
    endfunction

    function automatic vec_t mk(input logic we, input logic [AW-1:0] wa, input logic [NM-1:0] wm,
                                input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                                input logic [DW-1:0] ed);
        vec_t v;
        v.wr_en = we; v.wr_addr = wa; v.wr_mask = wm; v.wr_data = wd;
        v.rd_en = re; v.rd_addr = ra; v.exp_data = ed;
        return v;
    endfunction

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got[63:0]=%h want[63:0]=%h", name, cyc, act[63:0], exp[63:0]);
        end
    endtask

    task automatic drive(input vec_t v);
        wr_en = v.wr_en; wr_addr = v.wr_addr; wr_mask = v.wr_mask; wr_data = v.wr_data;
        rd_en = v.rd_en; rd_addr = v.rd_addr;
    endtask

    task automatic model_clear();
        pv[0] = 1'b0; pv[1] = 1'b0;
        pd[0] = '0;   pd[1] = '0;
        held  = '0;
    endtask

    // One clock; the expected output is the read issued LAT-1 cycles earlier, data held otherwise.
    task automatic step_check(input logic rv, input logic [DW-1:0] rdx, input string tag);
        @(posedge clk);
        #1;
        cyc++;
        pv[1] = pv[0]; pd[1] = pd[0];
        pv[0] = rv;    pd[0] = rdx;
        if (pv[LAT-1]) held = pd[LAT-1];
        chk_bit({tag, "_valid"}, rd_valid, pv[LAT-1]);
        chk_data({tag, "_data"}, rd_data, held);
    endtask

    vec_t          tbl [$];
    logic [NM-1:0] full;
    logic [DW-1:0] m10;
    vec_t          idle;

    initial begin
        full = '1;
        m10  = rep(8'h11);
        m10[7:0]   = 8'hFF;
        m10[23:16] = 8'hFF;
        idle = mk(1'b0, 8'h00, '0, '0, 1'b0, 8'h00, '0);
        model_clear();

        tbl.push_back(idle);
        tbl.push_back(idle);
        tbl.push_back(idle);
        tbl.push_back(mk(1'b1, 8'h05, full,    rep(8'hA5), 1'b0, 8'h00, '0));
        tbl.push_back(mk(1'b0, 8'h00, '0,      '0,         1'b1, 8'h05, rep(8'hA5)));
        tbl.push_back(mk(1'b1, 8'h10, full,    rep(8'h11), 1'b0, 8'h00, '0));
        tbl.push_back(mk(1'b1, 8'h10, 128'h5,  rep(8'hFF), 1'b1, 8'h10, m10));
        tbl.push_back(mk(1'b0, 8'h00, '0,      '0,         1'b1, 8'h10, m10));
        tbl.push_back(mk(1'b1, 8'h30, full,    rep(8'h5A), 1'b0, 8'h00, '0));
        tbl.push_back(mk(1'b1, 8'h30, '0,      rep(8'h00), 1'b1, 8'h05, rep(8'hA5)));
        tbl.push_back(mk(1'b0, 8'h00, '0,      '0,         1'b1, 8'h30, rep(8'h5A)));
        tbl.push_back(mk(1'b1, 8'h30, '0,      rep(8'hFF), 1'b1, 8'h30, rep(8'h5A)));
        tbl.push_back(idle);
        tbl.push_back(mk(1'b1, 8'h05, full,    rep(8'h3C), 1'b1, 8'h10, m10));
        tbl.push_back(mk(1'b0, 8'h00, '0,      '0,         1'b1, 8'h05, rep(8'h3C)));
        tbl.push_back(mk(1'b1, 8'h05, full,    rep(8'h77), 1'b0, 8'h00, '0));
        tbl.push_back(idle);
        tbl.push_back(mk(1'b0, 8'h00, '0,      '0,         1'b1, 8'h05, rep(8'h77)));
        tbl.push_back(idle);
        tbl.push_back(idle);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_bit("reset_valid", rd_valid, 1'b0);
        chk_data("reset_data", rd_data, '0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            step_check(tbl[i].rd_en, tbl[i].exp_data, $sformatf("tbl%0d", i));
        end

        // Full-array write of address patterns, then back-to-back reads of every address
        for (int a = 0; a < DEP; a++) begin
            drive(mk(1'b1, a[AW-1:0], full, rep(a[7:0]), 1'b0, 8'h00, '0));
            step_check(1'b0, '0, "fill");
        end
        for (int a = 0; a < DEP; a++) begin
            drive(mk(1'b0, 8'h00, '0, '0, 1'b1, a[AW-1:0], '0));
            step_check(1'b1, rep(a[7:0]), "sweep");
        end
        drive(idle);
        for (int k = 0; k < LAT + 1; k++) step_check(1'b0, '0, "sweep_drain");

        // Read 0x20 then reset mid-flight; a write held during reset must not land
        drive(mk(1'b0, 8'h00, '0, '0, 1'b1, 8'h20, '0));
        step_check(1'b1, rep(8'h20), "rst_rd");
        drive(mk(1'b1, 8'h20, full, rep(8'hEE), 1'b0, 8'h00, '0));
        #2;
        rst = 1'b1;
        #1;
        chk_bit("rst_async_valid", rd_valid, 1'b0);
        chk_data("rst_async_data", rd_data, '0);
        model_clear();
        @(posedge clk);
        #1;
        drive(idle);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) step_check(1'b0, '0, "post_rst_idle");
        drive(mk(1'b0, 8'h00, '0, '0, 1'b1, 8'h20, '0));
        step_check(1'b1, rep(8'h20), "post_rst_rd");
        drive(idle);
        for (int k = 0; k < LAT; k++) step_check(1'b0, '0, "post_rst_drain");

        // Zero-mask collision on a read that also lands back-to-back with a full write
        drive(mk(1'b1, 8'h40, full, rep(8'hC3), 1'b0, 8'h00, '0));
        step_check(1'b0, '0, "zm_prefill");
        drive(mk(1'b1, 8'h40, '0, rep(8'h00), 1'b1, 8'h40, '0));
        step_check(1'b1, rep(8'hC3), "zm_collide");
        drive(mk(1'b1, 8'h40, full, rep(8'h99), 1'b1, 8'h40, '0));
        step_check(1'b1, rep(8'h99), "full_collide");
        drive(idle);
        for (int k = 0; k < LAT + 1; k++) step_check(1'b0, '0, "final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
